assemble_block: RTL and testbench
=================================

# assemble_block

Byte-to-block packer that sits directly upstream of the block streamer. Accepts a ready/valid byte stream, packs 16 consecutive bytes into a 16×8-bit block, and hands complete blocks to the downstream streamer with a one-cycle start pulse, but only while the streamer is idle. Two block slots (ping-pong) let byte collection continue while the streamer is busy. A flush request zero-pads a partial block so trailing data is not stranded.

## Interface
- BLOCK_BYTES, 16: bytes per block; fixed at 16 for this design.
- PAD_BYTE, 8'h00: fill value for flushed partial blocks.

- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset; one clock domain.
- byte_in  input  8  data byte.
- byte_valid_in  input  1  byte_in valid.
- byte_ready_out  output  1  block can accept a byte this cycle.
- flush_in  input  1  single-cycle request to pad and close the partial block.
- ds_idle_in  input  1  downstream streamer is idle and can take a block.
- block_out  output  [15:0][7:0]  block to downstream; index 0 = first byte received.
- start_out  output  1  one-cycle pulse; block_out is valid in that cycle.
- fill_level_out  output  5  bytes held in the slot currently filling (0–16).
- blocks_pending_out  output  2  full slots awaiting issue (0–2).

## Operation
- Slot states: EMPTY, FILLING, FULL. Write pointer selects the fill slot. Read pointer selects the issue slot. Both pointers toggle 0↔1.
- Byte accept: byte_valid_in && byte_ready_out. Byte goes to slot[wr][fill_level]. fill_level increments.
- byte_ready_out = 1 when slot[wr] is not FULL. It is purely combinational from registered state.
- On the 16th accepted byte: slot[wr] becomes FULL, wr toggles, fill_level returns to 0.
- Flush with fill_level > 0: bytes fill_level..15 take the value PAD_BYTE. The slot becomes FULL and wr toggles, all in one cycle.
- Flush with fill_level == 0: ignored.
- Flush in the same cycle as a byte accept: the byte is stored first, then padding applies. If that byte is the 16th, there is nothing left to pad and the flush is consumed.
- Issue FSM states:
  - READY: if slot[rd] is FULL and ds_idle_in = 1, register block_out ← slot[rd], pulse start_out, free slot[rd] (EMPTY), toggle rd, go to HOLD.
  - HOLD: exactly one cycle, ds_idle_in is ignored, then return to READY. This covers the cycle the streamer needs to leave its idle state.
- block_out holds its last issued value until the next issue.
- blocks_pending_out counts FULL slots.
- A freed slot can accept bytes starting the cycle after issue.

## Timing
- Reset (rst_in low, asynchronous): all slots EMPTY, wr = rd = 0, fill_level_out = 0, blocks_pending_out = 0, start_out = 0, block_out = 0, FSM in READY.
- Resulting reset output: byte_ready_out = 1 once rst_in is released.
- Reset mid-operation: partial and full blocks are discarded, and no start_out is issued for them.
- Latency: 16th byte accepted at cycle N → start_out at N+1 at the earliest, when ds_idle_in = 1 and the FSM is in READY.
- Minimum spacing between start_out pulses is 2 cycles.
- Back-pressure: with both slots FULL, byte_ready_out = 0. It returns to 1 the cycle after the next issue.
- Sustained throughput: with the streamer never busy, one block per 16 byte cycles and no stalls.

## Structure
- A shared package holds BLOCK_BYTES, the slot_state_t enum (EMPTY/FILLING/FULL), the issue FSM enum (READY/HOLD), and the block_t typedef (logic [15:0][7:0]). The streamer imports the same block_t.
- One sub-module is natural: block_slot. It holds one 16-byte register plus its state, with ports for byte write, pad, and free. assemble_block instantiates two of them and adds the pointers and the issue FSM.

## Test plan
- Bytes 8'h00..8'h0F sent back-to-back, ds_idle_in = 1 → single start_out one cycle after byte 0x0F; block_out[0] = 8'h00, block_out[15] = 8'h0F.
- 48 bytes sent while ds_idle_in = 0 → byte_ready_out drops after byte 32 and blocks_pending_out = 2. Raising ds_idle_in gives start_out; ready returns the next cycle. All three blocks arrive in order.
- 5 bytes 8'hA1..8'hA5 followed by flush_in → block_out[0..4] = A1..A5, [5..15] = 8'h00, fill_level_out = 0.
- flush_in with fill_level_out = 0 → no start_out, no state change. flush_in together with the 16th byte → exactly one block, no padding.
- ds_idle_in held at 1 continuously across two full blocks → start_out pulses are at least 2 cycles apart and never in consecutive cycles.
- rst_in asserted after 10 bytes and one full pending block → outputs at reset values immediately. No start_out for the lost data. A fresh 16 bytes then produce a correct block.

Source files
------------

// File: rtl/assemble_block_pkg.sv
// Shared types for the byte-to-block packer and the downstream block streamer.
package assemble_block_pkg;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h00;
  localparam logic [4:0] FULL_LEVEL  = 5'(BLOCK_BYTES);

  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } slot_state_t;

  typedef enum logic {
    READY,
    HOLD
  } issue_state_t;

endpackage

// File: rtl/block_slot.sv
// One 16-byte block slot: byte write, pad-and-close, and free on issue.
module block_slot
  import assemble_block_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [7:0]  wr_data,
  input  logic        close_en,
  input  logic [4:0]  pad_from,
  input  logic        free_en,
  output slot_state_t state,
  output block_t      data
);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= EMPTY;
    end else if (free_en) begin
      state <= EMPTY;
    end else if (close_en) begin
      state <= FULL;
    end else if (wr_en) begin
      state <= FILLING;
    end
  end

  // NOTE: the byte storage is deliberately not reset; every byte is either written
  // or padded before the slot can become FULL, so stale contents are never issued.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (wr_en && (4'(i) == wr_idx)) begin
        data[i] <= wr_data;
      end else if (close_en && (5'(i) >= pad_from)) begin
        data[i] <= PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/assemble_block.sv
// Packs a ready/valid byte stream into 16-byte blocks held in two ping-pong slots
// and issues each full block to the streamer with a start pulse while it is idle.
module assemble_block
  import assemble_block_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       byte_ready_out,
  input  logic       flush_in,
  input  logic       ds_idle_in,
  output block_t     block_out,
  output logic       start_out,
  output logic [4:0] fill_level_out,
  output logic [1:0] blocks_pending_out
);

  logic         wr_ptr;
  logic         rd_ptr;
  logic [4:0]   fill_level;
  logic [4:0]   new_level;
  logic         accept;
  logic         close;
  logic         issue_fire;
  issue_state_t issue_q;
  issue_state_t issue_next;
  slot_state_t  slot_state [2];
  block_t       slot_data  [2];

  assign byte_ready_out = (slot_state[wr_ptr] != FULL);
  assign accept         = byte_valid_in && byte_ready_out;
  assign new_level      = fill_level + 5'(accept);
  // A flush pads from the level after this cycle's byte; a 16th byte closes on its own.
  assign close          = (new_level == FULL_LEVEL) || (flush_in && (new_level != 5'd0));

  for (genvar s = 0; s < 2; s++) begin : g_slot
    block_slot u_slot (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .wr_en    (accept && (wr_ptr == 1'(s))),
      .wr_idx   (fill_level[3:0]),
      .wr_data  (byte_in),
      .close_en (close && (wr_ptr == 1'(s))),
      .pad_from (new_level),
      .free_en  (issue_fire && (rd_ptr == 1'(s))),
      .state    (slot_state[s]),
      .data     (slot_data[s])
    );
  end

  // NOTE: every combinational output gets a default before the case, so no latch is inferred.
  always_comb begin
    issue_next = issue_q;
    issue_fire = 1'b0;
    case (issue_q)
      READY: begin
        if ((slot_state[rd_ptr] == FULL) && ds_idle_in) begin
          issue_fire = 1'b1;
          issue_next = HOLD;
        end
      end
      HOLD:    issue_next = READY;
      default: issue_next = READY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      issue_q    <= READY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fill_level <= 5'd0;
      block_out  <= '0;
      start_out  <= 1'b0;
    end else begin
      issue_q    <= issue_next;
      start_out  <= issue_fire;
      fill_level <= close ? 5'd0 : new_level;
      if (close) begin
        wr_ptr <= ~wr_ptr;
      end
      if (issue_fire) begin
        block_out <= slot_data[rd_ptr];
        rd_ptr    <= ~rd_ptr;
      end
    end
  end

  assign fill_level_out     = fill_level;
  assign blocks_pending_out = 2'(slot_state[0] == FULL) + 2'(slot_state[1] == FULL);

endmodule

// File: tb/tb_assemble_block.sv
// Directed self-checking bench for assemble_block: packing, back-pressure, flush,
// issue spacing and mid-operation reset.
module tb_assemble_block;
  import assemble_block_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic       byte_ready_out;
  logic       flush_in;
  logic       ds_idle_in;
  block_t     block_out;
  logic       start_out;
  logic [4:0] fill_level_out;
  logic [1:0] blocks_pending_out;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     adj_cnt = 0;
  block_t rx_q [$];
  int     start_cyc_q [$];

  assemble_block dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .byte_in            (byte_in),
    .byte_valid_in      (byte_valid_in),
    .byte_ready_out     (byte_ready_out),
    .flush_in           (flush_in),
    .ds_idle_in         (ds_idle_in),
    .block_out          (block_out),
    .start_out          (start_out),
    .fill_level_out     (fill_level_out),
    .blocks_pending_out (blocks_pending_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  // Collect every issued block, and flag pulses in back-to-back cycles.
  always @(negedge clk_in) begin
    if (start_out) begin
      if ((start_cyc_q.size() > 0) && (cyc - start_cyc_q[$] < 2)) adj_cnt++;
      rx_q.push_back(block_out);
      start_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_cyc_q.delete();
    adj_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    int budget;
    budget        = 0;
    byte_in       = b;
    byte_valid_in = 1'b1;
    flush_in      = fl;
    while (!byte_ready_out && budget < 200) begin
      tick();
      budget++;
    end
    if (!byte_ready_out) check("ready_timeout", 1'b0, 1'b1);
    tick();
    byte_valid_in = 1'b0;
    flush_in      = 1'b0;
  endtask

  function automatic block_t ramp(input logic [7:0] base);
    block_t r;
    for (int i = 0; i < BLOCK_BYTES; i++) r[i] = base + 8'(i);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    block_t exp_blk;

    rst_in        = 1'b0;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    flush_in      = 1'b0;
    ds_idle_in    = 1'b0;
    wait_cycles(3);
    rst_in = 1'b1;
    tick();

    // Reset state
    check("rst_ready",   byte_ready_out, 1'b1);
    check("rst_fill",    fill_level_out, 5'd0);
    check("rst_pending", blocks_pending_out, 2'd0);
    check("rst_start",   start_out, 1'b0);
    check("rst_block",   block_out, 128'd0);

    // Single block 00..0F with streamer idle
    ds_idle_in = 1'b1;
    clear_rx();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    check("t1_start_early", start_out, 1'b0);
    check("t1_pending",     blocks_pending_out, 2'd1);
    check("t1_fill",        fill_level_out, 5'd0);
    tick();
    check("t1_start",  start_out, 1'b1);
    check("t1_byte0",  block_out[0], 8'h00);
    check("t1_byte15", block_out[15], 8'h0F);
    check("t1_block",  block_out, ramp(8'h00));
    tick();
    check("t1_pulse_once", start_out, 1'b0);
    wait_cycles(3);
    check("t1_count", rx_q.size(), 1);

    // Back-pressure: 48 bytes with streamer busy
    ds_idle_in = 1'b0;
    clear_rx();
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
    check("t2_ready_low", byte_ready_out, 1'b0);
    check("t2_pending2",  blocks_pending_out, 2'd2);
    check("t2_fill",      fill_level_out, 5'd0);
    ds_idle_in = 1'b1;
    check("t2_ready_still_low", byte_ready_out, 1'b0);
    tick();
    check("t2_start",      start_out, 1'b1);
    check("t2_ready_back", byte_ready_out, 1'b1);
    check("t2_first_blk",  block_out, ramp(8'h00));
    for (int i = 32; i < 48; i++) send_byte(8'(i), 1'b0);
    wait_cycles(6);
    check("t2_count", rx_q.size(), 3);
    if (rx_q.size() >= 3) begin
      check("t2_blk0", rx_q[0], ramp(8'd0));
      check("t2_blk1", rx_q[1], ramp(8'd16));
      check("t2_blk2", rx_q[2], ramp(8'd32));
      check("t2_gap",  start_cyc_q[1] - start_cyc_q[0], 2);
    end
    check("t2_pending0", blocks_pending_out, 2'd0);

    // Partial block A1..A5 then flush
    clear_rx();
    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), 1'b0);
    check("t3_fill5", fill_level_out, 5'd5);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("t3_fill0", fill_level_out, 5'd0);
    wait_cycles(4);
    exp_blk = '0;
    for (int i = 0; i < 5; i++) exp_blk[i] = 8'hA1 + 8'(i);
    check("t3_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t3_padded", rx_q[0], exp_blk);

    // Flush while empty is ignored; flush with the 16th byte adds no padding
    clear_rx();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    wait_cycles(4);
    check("t4_empty_flush_count",   rx_q.size(), 0);
    check("t4_empty_flush_pending", blocks_pending_out, 2'd0);
    check("t4_empty_flush_fill",    fill_level_out, 5'd0);
    for (int i = 0; i < 15; i++) send_byte(8'h50 + 8'(i), 1'b0);
    check("t4_fill15", fill_level_out, 5'd15);
    send_byte(8'h5F, 1'b1);
    check("t4_fill0", fill_level_out, 5'd0);
    wait_cycles(4);
    check("t4_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t4_block", rx_q[0], ramp(8'h50));
    check("t4_pending0", blocks_pending_out, 2'd0);

    // Streamer idle throughout two back-to-back blocks
    clear_rx();
    for (int i = 0; i < 32; i++) send_byte(8'h80 + 8'(i), 1'b0);
    wait_cycles(4);
    check("t5_count",    rx_q.size(), 2);
    check("t5_adjacent", adj_cnt, 0);
    if (rx_q.size() >= 2) begin
      check("t5_blk0", rx_q[0], ramp(8'h80));
      check("t5_blk1", rx_q[1], ramp(8'h90));
      check("t5_gap_ge2", (start_cyc_q[1] - start_cyc_q[0]) >= 2, 1'b1);
    end

    // Reset with one full block pending and 10 bytes in the filling slot
    ds_idle_in = 1'b0;
    clear_rx();
    for (int i = 0; i < 26; i++) send_byte(8'h10 + 8'(i), 1'b0);
    check("t6_pending1", blocks_pending_out, 2'd1);
    check("t6_fill10",   fill_level_out, 5'd10);
    #2 rst_in = 1'b0;
    #1;
    check("t6_rst_fill",    fill_level_out, 5'd0);
    check("t6_rst_pending", blocks_pending_out, 2'd0);
    check("t6_rst_start",   start_out, 1'b0);
    check("t6_rst_block",   block_out, 128'd0);
    check("t6_rst_ready",   byte_ready_out, 1'b1);
    ds_idle_in = 1'b1;
    tick();
    rst_in = 1'b1;
    wait_cycles(3);
    check("t6_no_lost_issue", rx_q.size(), 0);
    for (int i = 0; i < 16; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    wait_cycles(3);
    check("t6_fresh_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t6_fresh_block", rx_q[0], ramp(8'hC0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
